mult_share_ctrl: RTL and testbench

//   Controller that shares one sequential Multiplier instance among NREQ requesters.

---
 rtl/mult_share_ctrl_pkg.sv | 24 ++
 rtl/mult_share_ctrl_rr_arbiter.sv | 43 ++++
 rtl/mult_share_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mult_share_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_ctrl_pkg.sv
// mult_share_ctrl_pkg
//   Shared definitions for the multiplier-sharing controller:
//   - ctrlState_e : controller FSM state encoding
//   - clog2       : ceiling log2 used to size the pointer and watchdog fields
package mult_share_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } ctrlState_e;

   // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(21) = 5.
   function automatic int clog2(input int value);
      int result;
      result = 32'sd0;
      for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
         result = result + 32'sd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin arbiter. Picks the first asserted request
//   at or after ptr, wrapping from NREQ-1 back to 0.
// Ports:
//   req       in  NREQ  request vector
//   ptr       in  GW    highest-priority index for this decision
//   grant     out NREQ  one-hot grant (all zero when no request)
//   grant_idx out GW    binary index of the granted requester
//   any       out 1     at least one request present
module rr_arbiter
   import mult_share_ctrl_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int GW   = (clog2(NREQ) > 32'sd1) ? clog2(NREQ) : 32'sd1
) (
   input  logic [NREQ-1:0] req,
   input  logic [GW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [GW-1:0]   grant_idx,
   output logic            any
);

   int candIdx_s;

   // Scan candidates starting at ptr; the first hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      candIdx_s = 32'sd0;
      for (int i = 0; i < NREQ; i++) begin
         candIdx_s = (int'(ptr) + i) % NREQ;
         if (!any && req[candIdx_s]) begin
            any                = 1'b1;
            grant[candIdx_s]   = 1'b1;
            grant_idx          = GW'(candIdx_s);
         end else begin
            // a higher-priority candidate already won, or no request here
         end
      end
   end

endmodule

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
//   Shares one sequential multiplier among NREQ requesters. A round-robin
//   arbiter picks a requester in IDLE, its operands are latched, the multiplier
//   is started for one cycle, and the product is returned to that owner.
//   A watchdog abandons the operation if productDone never arrives.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester request handshake (ready is IDLE-only)
//   req_a/req_b         packed operands, slice i = [i*WIDTH +: WIDTH]
//   resp_valid/ready    one-hot response handshake to the owner
//   resp_product        registered product, qualified by resp_valid
//   timeout             one-cycle pulse on watchdog abort
//   busy                controller is not IDLE
//   mult_*              connection to the shared multiplier
module mult_share_ctrl
   import mult_share_ctrl_pkg::*;
#(
   parameter int WIDTH   = 1024,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 2 * WIDTH + 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       resp_valid,
   input  logic [NREQ-1:0]       resp_ready,
   output logic [2*WIDTH-1:0]    resp_product,
   output logic                  timeout,
   output logic                  busy,
   output logic                  mult_start,
   output logic [WIDTH-1:0]      mult_a,
   output logic [WIDTH-1:0]      mult_b,
   input  logic [2*WIDTH-1:0]    mult_product,
   input  logic                  mult_done
);

   localparam int GW  = (clog2(NREQ) > 32'sd1) ? clog2(NREQ) : 32'sd1;
   localparam int WDW = clog2(TIMEOUT + 32'sd1);

   ctrlState_e         state_r;
   ctrlState_e         nextState_s;
   logic [GW-1:0]      rrPtr_r;
   logic [GW-1:0]      owner_r;
   logic [GW-1:0]      ownerNext_s;
   logic [WDW-1:0]     wdog_r;
   logic               wdogExpired_s;
   logic [WIDTH-1:0]   multA_r;
   logic [WIDTH-1:0]   multB_r;
   logic [2*WIDTH-1:0] product_r;
   logic               timeout_r;
   logic [NREQ-1:0]    grantOneHot_s;
   logic [GW-1:0]      grantIdx_s;
   logic               grantAny_s;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req       (req_valid),
      .ptr       (rrPtr_r),
      .grant     (grantOneHot_s),
      .grant_idx (grantIdx_s),
      .any       (grantAny_s)
   );

   // After completion or abort, priority moves to the requester after the owner.
   assign ownerNext_s   = (owner_r == GW'(NREQ - 1)) ? {GW{1'b0}} : owner_r + GW'(1);
   assign wdogExpired_s = (wdog_r == WDW'(TIMEOUT - 1));

   // Next-state decode and the IDLE-only accept pulse.
   always_comb begin
      nextState_s = state_r;
      req_ready   = '0;
      case (state_r)
         IDLE: begin
            if (grantAny_s) begin
               req_ready   = grantOneHot_s;
               nextState_s = LAUNCH;
            end else begin
               nextState_s = IDLE;
            end
         end
         LAUNCH: nextState_s = WAIT;
         WAIT: begin
            if (mult_done) begin
               nextState_s = RESP;
            end else if (wdogExpired_s) begin
               nextState_s = IDLE;
            end else begin
               nextState_s = WAIT;
            end
         end
         RESP: begin
            if (resp_ready[owner_r]) begin
               nextState_s = IDLE;
            end else begin
               nextState_s = RESP;
            end
         end
         default: nextState_s = IDLE;
      endcase
   end

   // One-hot response valid for the current owner while in RESP.
   always_comb begin
      resp_valid = '0;
      if (state_r == RESP) begin
         resp_valid[owner_r] = 1'b1;
      end else begin
         resp_valid = '0;
      end
   end

   // State, operand/product, owner, pointer and watchdog registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         rrPtr_r   <= '0;
         owner_r   <= '0;
         wdog_r    <= '0;
         multA_r   <= '0;
         multB_r   <= '0;
         product_r <= '0;
         timeout_r <= 1'b0;
      end else begin
         state_r   <= nextState_s;
         timeout_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grantAny_s) begin
                  multA_r <= req_a[int'(grantIdx_s) * WIDTH +: WIDTH];
                  multB_r <= req_b[int'(grantIdx_s) * WIDTH +: WIDTH];
                  owner_r <= grantIdx_s;
               end
            end
            LAUNCH: wdog_r <= '0;
            WAIT: begin
               if (mult_done) begin
                  product_r <= mult_product;
               end else if (wdogExpired_s) begin
                  // abandon: no response, but the owner loses its priority
                  timeout_r <= 1'b1;
                  rrPtr_r   <= ownerNext_s;
               end else begin
                  wdog_r <= wdog_r + WDW'(1);
               end
            end
            RESP: begin
               if (resp_ready[owner_r]) begin
                  rrPtr_r <= ownerNext_s;
               end
            end
            default: ;
         endcase
      end
   end

   // The start pulse is a pure decode of the LAUNCH state register.
   assign mult_start   = (state_r == LAUNCH);
   assign busy         = (state_r != IDLE);
   assign timeout      = timeout_r;
   assign mult_a       = multA_r;
   assign mult_b       = multB_r;
   assign resp_product = product_r;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl
//   Directed bench for mult_share_ctrl (WIDTH=8, NREQ=4, TIMEOUT=20) with a
//   behavioural fixed-latency multiplier that can be stubbed to never finish.
module tb_mult_share_ctrl;

   localparam int WIDTH   = 8;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 20;
   localparam int LAT     = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       resp_valid;
   logic [NREQ-1:0]       resp_ready;
   logic [2*WIDTH-1:0]    resp_product;
   logic                  timeout;
   logic                  busy;
   logic                  mult_start;
   logic [WIDTH-1:0]      mult_a;
   logic [WIDTH-1:0]      mult_b;
   logic [2*WIDTH-1:0]    mult_product;
   logic                  mult_done;

   int nChecks = 0;
   int nFail   = 0;
   int startCount = 0;

   // multiplier model state
   logic [3:0]         mCnt;
   logic [WIDTH-1:0]   mA, mB;
   logic [2*WIDTH-1:0] mProd;
   logic               mDone;
   logic               stub;
   logic               injectDone;

   mult_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_product (resp_product),
      .timeout      (timeout),
      .busy         (busy),
      .mult_start   (mult_start),
      .mult_a       (mult_a),
      .mult_b       (mult_b),
      .mult_product (mult_product),
      .mult_done    (mult_done)
   );

   always #5 clk = ~clk;

   // Fixed-latency sequential multiplier on the same reset.
   always @(posedge clk) begin
      if (rst) begin
         mCnt  <= 4'd0;
         mDone <= 1'b0;
         mProd <= 16'd0;
         mA    <= 8'd0;
         mB    <= 8'd0;
      end else begin
         mDone <= 1'b0;
         if (mult_start) begin
            mCnt <= 4'(LAT);
            mA   <= mult_a;
            mB   <= mult_b;
         end else if (mCnt != 4'd0) begin
            mCnt <= mCnt - 4'd1;
            if (mCnt == 4'd1) begin
               mDone <= !stub;
               mProd <= 16'(mA) * 16'(mB);
            end
         end
      end
   end

   assign mult_done    = mDone | injectDone;
   assign mult_product = mProd;

   always @(posedge clk) begin
      if (mult_start) startCount <= startCount + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic setOp(input int p, input logic [7:0] a, input logic [7:0] b);
      req_a[p*WIDTH +: WIDTH] = a;
      req_b[p*WIDTH +: WIDTH] = b;
   endtask

   task automatic waitReady(input string tag);
      int n;
      n = 0;
      #1;
      while (req_ready == 4'd0 && n < 50) begin
         tick();
         n++;
      end
      chk(tag, 32'(req_ready != 4'd0), 32'd1);
   endtask

   task automatic waitResp(input string tag);
      int n;
      n = 0;
      while (resp_valid == 4'd0 && n < 60) begin
         tick();
         n++;
      end
      chk(tag, 32'(resp_valid != 4'd0), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      int seq [5] = '{0, 1, 2, 3, 0};
      int prods [4] = '{2, 6, 12, 20};
      int startBase;
      int early;
      int rvSeen;

      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = '0;
      stub = 1'b0; injectDone = 1'b0;
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mult_start", 32'(mult_start), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_mult_a", 32'(mult_a), 32'd0);
      chk("rst_product", 32'(resp_product), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      tick();

      // 1: single request on port 2
      resp_ready = 4'b1111;
      setOp(2, 8'd3, 8'd5);
      startBase = startCount;
      req_valid = 4'b0100;
      waitReady("t1_ready_seen");
      chk("t1_req_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = 4'b0000;
      chk("t1_start", 32'(mult_start), 32'd1);
      chk("t1_mult_a", 32'(mult_a), 32'd3);
      chk("t1_mult_b", 32'(mult_b), 32'd5);
      chk("t1_ready_launch", 32'(req_ready), 32'd0);
      waitResp("t1_resp_seen");
      chk("t1_resp_valid", 32'(resp_valid), 32'h4);
      chk("t1_product", 32'(resp_product), 32'd15);
      tick();
      chk("t1_busy_after", 32'(busy), 32'd0);
      chk("t1_resp_after", 32'(resp_valid), 32'd0);
      chk("t1_start_count", 32'(startCount - startBase), 32'd1);

      // 2: all requesters held high from reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) setOp(i, 8'(i + 1), 8'(i + 2));
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         waitReady("t2_ready_seen");
         chk("t2_grant", 32'(req_ready), 32'(1) << seq[k]);
         tick();
         waitResp("t2_resp_seen");
         chk("t2_resp_valid", 32'(resp_valid), 32'(1) << seq[k]);
         chk("t2_product", 32'(resp_product), 32'(prods[seq[k]]));
         tick();
      end
      req_valid = 4'b0000;

      // 3: port 1, 0xFF*0xFF, response held off for 5 cycles
      setOp(1, 8'hFF, 8'hFF);
      resp_ready = 4'b0000;
      req_valid  = 4'b0010;
      waitReady("t3_ready_seen");
      chk("t3_grant", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'b0000;
      waitResp("t3_resp_seen");
      req_valid = 4'b1111;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("t3_resp_valid_hold", 32'(resp_valid), 32'h2);
         chk("t3_product_hold", 32'(resp_product), 32'hFE01);
         chk("t3_no_req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      resp_ready = 4'b1101;
      tick();
      chk("t3_non_owner_ignored", 32'(resp_valid), 32'h2);
      resp_ready = 4'b0010;
      req_valid  = 4'b0000;
      tick();
      chk("t3_busy_after", 32'(busy), 32'd0);
      chk("t3_resp_after", 32'(resp_valid), 32'd0);

      // 4: multiplier never finishes -> watchdog abort
      stub = 1'b1;
      resp_ready = 4'b1111;
      setOp(0, 8'd9, 8'd9);
      req_valid = 4'b0001;
      waitReady("t4_ready_seen");
      chk("t4_grant", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b0000;
      chk("t4_start", 32'(mult_start), 32'd1);
      early = 0;
      rvSeen = 0;
      for (int k = 1; k <= TIMEOUT; k++) begin
         tick();
         if (timeout) early++;
         if (resp_valid != 4'd0) rvSeen++;
      end
      tick();
      chk("t4_timeout_pulse", 32'(timeout), 32'd1);
      chk("t4_no_early_timeout", 32'(early), 32'd0);
      chk("t4_idle_after", 32'(busy), 32'd0);
      chk("t4_no_resp", 32'(rvSeen + int'(resp_valid)), 32'd0);
      tick();
      chk("t4_timeout_one_cycle", 32'(timeout), 32'd0);
      stub = 1'b0;
      setOp(1, 8'd7, 8'd9);
      req_valid = 4'b0010;
      waitReady("t4_next_ready_seen");
      chk("t4_next_grant", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'b0000;
      waitResp("t4_next_resp_seen");
      chk("t4_next_resp_valid", 32'(resp_valid), 32'h2);
      chk("t4_next_product", 32'(resp_product), 32'd63);
      tick();

      // 5: reset during WAIT
      setOp(2, 8'd10, 8'd11);
      req_valid = 4'b0100;
      waitReady("t5_ready_seen");
      chk("t5_grant", 32'(req_ready), 32'h4);
      tick();
      req_valid = 4'b0000;
      tick();
      chk("t5_busy_wait", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_busy_rst", 32'(busy), 32'd0);
      chk("t5_resp_rst", 32'(resp_valid), 32'd0);
      chk("t5_start_rst", 32'(mult_start), 32'd0);
      injectDone = 1'b1;
      tick();
      injectDone = 1'b0;
      rvSeen = 0;
      for (int i = 0; i < 10; i++) begin
         if (busy || resp_valid != 4'd0) rvSeen++;
         tick();
      end
      chk("t5_done_ignored", 32'(rvSeen), 32'd0);
      setOp(0, 8'd2, 8'd3);
      req_valid = 4'b1111;
      waitReady("t5_after_ready_seen");
      chk("t5_ptr_reset_grant", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b0000;
      waitResp("t5_after_resp_seen");
      chk("t5_after_resp_valid", 32'(resp_valid), 32'h1);
      chk("t5_after_product", 32'(resp_product), 32'd6);
      tick();

      // 6: port 3 drops its request during WAIT
      setOp(3, 8'd12, 8'd13);
      req_valid = 4'b1000;
      waitReady("t6_ready_seen");
      chk("t6_grant", 32'(req_ready), 32'h8);
      tick();
      tick();
      req_valid = 4'b0000;
      waitResp("t6_resp_seen");
      chk("t6_resp_valid", 32'(resp_valid), 32'h8);
      chk("t6_product", 32'(resp_product), 32'd156);
      tick();
      chk("t6_busy_after", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
